// File: rtl/aes_iter_cipher_pkg.sv
// aes_iter_cipher_pkg
//   Shared AES-256 definitions for the iterative forward cipher:
//   block/round constants, the expanded round-key bundle type, the FSM
//   state encoding, the forward S-box table and GF(2^8) helper functions.
//   Byte 0 of a block (FIPS-197 ordering) lives in bits [127:120], and the
//   state is column-major, so byte i is row i%4, column i/4.
package aes_iter_cipher_pkg;

  localparam int N_ROUNDS   = 14;
  localparam int BLOCK_BITS = 128;

  // Expanded keys 0..N_ROUNDS, each in the same byte order as tdata.
  typedef logic [N_ROUNDS:0][BLOCK_BITS-1:0] round_keys_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUND = 2'd1,
    ST_HOLD  = 2'd2
  } fsm_state_e;

  // Forward S-box, entry 0 is the leftmost element.
  localparam logic [0:255][7:0] SBOX = {
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic logic [7:0] sbox_lookup(input logic [7:0] b);
    return SBOX[b];
  endfunction

  // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul3(input logic [7:0] b);
    return xtime(b) ^ b;
  endfunction

endpackage

// File: rtl/aes_iter_cipher_round.sv
// aes_enc_round_comb
//   One purely combinational AES forward round:
//   SubBytes -> ShiftRows -> MixColumns (optional) -> AddRoundKey.
//   Ports:
//     state   in  128  current cipher state (byte 0 in [127:120])
//     key     in  128  round key for this round
//     mix_en  in  1    apply MixColumns (low for the final round)
//     result  out 128  next cipher state
module aes_enc_round_comb
  import aes_iter_cipher_pkg::*;
(
  input  logic [BLOCK_BITS-1:0] state,
  input  logic [BLOCK_BITS-1:0] key,
  input  logic                  mix_en,
  output logic [BLOCK_BITS-1:0] result
);

  logic [7:0] sb_s [16];
  logic [7:0] sr_s [16];
  logic [7:0] mc_s [16];

  for (genvar i = 0; i < 16; i++) begin : g_sub
    assign sb_s[i] = sbox_lookup(state[127-8*i -: 8]);
  end

  for (genvar c = 0; c < 4; c++) begin : g_col
    // Row r of column c takes the byte from column (c+r)%4: left rotate by r.
    for (genvar r = 0; r < 4; r++) begin : g_row
      assign sr_s[4*c+r] = sb_s[4*((c+r)%4)+r];
    end

    assign mc_s[4*c+0] = xtime(sr_s[4*c+0]) ^ gf_mul3(sr_s[4*c+1]) ^ sr_s[4*c+2] ^ sr_s[4*c+3];
    assign mc_s[4*c+1] = sr_s[4*c+0] ^ xtime(sr_s[4*c+1]) ^ gf_mul3(sr_s[4*c+2]) ^ sr_s[4*c+3];
    assign mc_s[4*c+2] = sr_s[4*c+0] ^ sr_s[4*c+1] ^ xtime(sr_s[4*c+2]) ^ gf_mul3(sr_s[4*c+3]);
    assign mc_s[4*c+3] = gf_mul3(sr_s[4*c+0]) ^ sr_s[4*c+1] ^ sr_s[4*c+2] ^ xtime(sr_s[4*c+3]);
  end

  for (genvar i = 0; i < 16; i++) begin : g_ark
    assign result[127-8*i -: 8] = (mix_en ? mc_s[i] : sr_s[i]) ^ key[127-8*i -: 8];
  end

endmodule

// File: rtl/aes_iter_cipher.sv
// aes_iter_cipher
//   Iterative AES-256 encryptor: one round datapath reused for 14 cycles.
//   Ports:
//     clk, reset                          rising-edge clock, sync active-high reset
//     aes_in_tdata/tvalid/tlast/tready    plaintext AXI-Stream slave
//     round_keys, round_keys_valid        expanded keys 0..14 and their qualifier
//     aes_out_tdata/tvalid/tlast/tready   ciphertext AXI-Stream master
//   A block accepted at edge T is presented on the output after edge T+14.
//   The HOLD cycle can hand off and accept a new block in the same cycle,
//   giving one block per 15 cycles when the output is never stalled.
module aes_iter_cipher
  import aes_iter_cipher_pkg::*;
#(
  parameter int ROUND_NUMBER = N_ROUNDS,
  parameter int TDATA_WIDTH  = BLOCK_BITS
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [TDATA_WIDTH-1:0] aes_in_tdata,
  input  logic                   aes_in_tvalid,
  input  logic                   aes_in_tlast,
  output logic                   aes_in_tready,
  input  round_keys_t            round_keys,
  input  logic                   round_keys_valid,
  output logic [TDATA_WIDTH-1:0] aes_out_tdata,
  output logic                   aes_out_tvalid,
  output logic                   aes_out_tlast,
  input  logic                   aes_out_tready
);

  localparam logic [3:0] LAST_RND = 4'(ROUND_NUMBER);

  fsm_state_e             fsm_q;
  fsm_state_e             fsm_d;
  logic [TDATA_WIDTH-1:0] state_q;
  logic [3:0]             rnd_q;
  logic                   last_q;

  logic                   in_accept_s;
  logic [BLOCK_BITS-1:0]  round_key_s;
  logic [BLOCK_BITS-1:0]  round_out_s;
  logic                   mix_en_s;

  assign in_accept_s = aes_in_tvalid & aes_in_tready;
  assign mix_en_s    = (rnd_q != LAST_RND);

  // Round-key select; rnd_q never exceeds LAST_RND while it is used.
  always_comb begin
    round_key_s = round_keys[0];
    if (rnd_q <= LAST_RND) begin
      round_key_s = round_keys[rnd_q];
    end else begin
      round_key_s = '0;
    end
  end

  aes_enc_round_comb u_round (
    .state  (state_q),
    .key    (round_key_s),
    .mix_en (mix_en_s),
    .result (round_out_s)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      fsm_q <= ST_IDLE;
    end else begin
      fsm_q <= fsm_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    fsm_d = fsm_q;
    case (fsm_q)
      ST_IDLE: begin
        if (in_accept_s) begin
          fsm_d = ST_ROUND;
        end else begin
          fsm_d = ST_IDLE;
        end
      end
      ST_ROUND: begin
        if (rnd_q == LAST_RND) begin
          fsm_d = ST_HOLD;
        end else begin
          fsm_d = ST_ROUND;
        end
      end
      ST_HOLD: begin
        if (aes_out_tready) begin
          // A same-cycle accept reloads immediately, keeping the 15-cycle cadence.
          fsm_d = in_accept_s ? ST_ROUND : ST_IDLE;
        end else begin
          fsm_d = ST_HOLD;
        end
      end
      default: begin
        fsm_d = ST_IDLE;
      end
    endcase
  end

  // FSM outputs: handshakes and the ciphertext presented only in HOLD.
  always_comb begin
    aes_in_tready  = 1'b0;
    aes_out_tvalid = 1'b0;
    aes_out_tdata  = '0;
    aes_out_tlast  = 1'b0;
    case (fsm_q)
      ST_IDLE: begin
        aes_in_tready = ~reset & round_keys_valid;
      end
      ST_ROUND: begin
        aes_in_tready = 1'b0;
      end
      ST_HOLD: begin
        aes_in_tready  = ~reset & round_keys_valid & aes_out_tready;
        aes_out_tvalid = 1'b1;
        aes_out_tdata  = state_q;
        aes_out_tlast  = last_q;
      end
      default: begin
        aes_in_tready = 1'b0;
      end
    endcase
  end

  // Cipher state, round counter and tlast register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= '0;
      rnd_q   <= 4'd0;
      last_q  <= 1'b0;
    end else if (in_accept_s) begin
      state_q <= aes_in_tdata ^ round_keys[0];
      rnd_q   <= 4'd1;
      last_q  <= aes_in_tlast;
    end else if (fsm_q == ST_ROUND) begin
      state_q <= round_out_s;
      if (rnd_q == LAST_RND) begin
        rnd_q <= 4'd0;
      end else begin
        rnd_q <= rnd_q + 4'd1;
      end
    end else begin
      state_q <= state_q;
      rnd_q   <= rnd_q;
      last_q  <= last_q;
    end
  end

endmodule
